// File: rtl/led_pkg.sv
// Shared register offsets, response codes, FSM state types and the byte-strobe merge helper
// for the AXI-Lite LED controller.
package led_pkg;

    localparam logic [7:0] OFF_LED_VAL    = 8'h00;
    localparam logic [7:0] OFF_LED_MODE   = 8'h04;
    localparam logic [7:0] OFF_BLINK_HALF = 8'h08;
    localparam logic [7:0] OFF_PWM_DUTY   = 8'h0C;
    localparam logic [7:0] OFF_STATUS     = 8'h10;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        StWAddr,
        StWData,
        StWResp
    } wr_state_e;

    typedef enum logic {
        StRAddr,
        StRData
    } rd_state_e;

    function automatic logic [31:0] apply_strb(input logic [31:0] cur,
                                               input logic [31:0] wdata,
                                               input logic [3:0]  strb);
        logic [31:0] res;
        res = cur;
        for (int k = 0; k < 4; k++) begin
            if (strb[k]) res[8*k +: 8] = wdata[8*k +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/AXI_LITE.sv
// 32-bit AXI-Lite bundle carrying its own clock and synchronous active-low reset.
interface AXI_LITE;

    logic        aclk;
    logic        aresetn;
    logic [31:0] awaddr;
    logic        awvalid;
    logic        awready;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        wvalid;
    logic        wready;
    logic [1:0]  bresp;
    logic        bvalid;
    logic        bready;
    logic [31:0] araddr;
    logic        arvalid;
    logic        arready;
    logic [31:0] rdata;
    logic [1:0]  rresp;
    logic        rvalid;
    logic        rready;

    modport master (
        input  aclk, aresetn,
        output awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        input  awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

    modport slave (
        input  aclk, aresetn,
        input  awaddr, awvalid, wdata, wstrb, wvalid, bready, araddr, arvalid, rready,
        output awready, wready, bresp, bvalid, arready, rdata, rresp, rvalid
    );

endinterface

// File: rtl/led_fx_gen.sv
// Blink timer, free-running PWM counter and the registered LED drive.
module led_fx_gen #(
    parameter int unsigned NUM_LEDS = 8,
    parameter int unsigned PWM_BITS = 8
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic [NUM_LEDS-1:0] led_val_i,
    input  logic [NUM_LEDS-1:0] led_mode_i,
    input  logic [31:0]         blink_half_i,
    input  logic [PWM_BITS:0]   pwm_duty_i,
    input  logic                restart_i,
    output logic [NUM_LEDS-1:0] led_o,
    output logic                phase_o
);

    logic [31:0]         blink_cnt_q, blink_cnt_d;
    logic                phase_q, phase_d;
    logic [PWM_BITS-1:0] pwm_cnt_q, pwm_cnt_d;
    logic [NUM_LEDS-1:0] led_q, led_d;
    logic                blink_stop, phase_eff, pwm_on;

    always_comb begin
        blink_stop  = (blink_half_i == '0);
        blink_cnt_d = blink_cnt_q + 32'd1;
        phase_d     = phase_q;
        if (restart_i) begin
            blink_cnt_d = '0;
            phase_d     = 1'b1;
        end else if (blink_stop) begin
            blink_cnt_d = blink_cnt_q;
        end else if (blink_cnt_q == blink_half_i) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
        end
    end

    // A stopped timer shows blink-mode LEDs as steady on; the phase register itself is left alone.
    always_comb begin
        pwm_cnt_d = pwm_cnt_q + PWM_BITS'(1);
        pwm_on    = (pwm_duty_i > {1'b0, pwm_cnt_q});
        phase_eff = phase_q | blink_stop;
        led_d     = pwm_on ? (led_val_i & (~led_mode_i | {NUM_LEDS{phase_eff}})) : '0;
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            blink_cnt_q <= '0;
            phase_q     <= 1'b0;
            pwm_cnt_q   <= '0;
            led_q       <= '0;
        end else begin
            blink_cnt_q <= blink_cnt_d;
            phase_q     <= phase_d;
            pwm_cnt_q   <= pwm_cnt_d;
            led_q       <= led_d;
        end
    end

    assign led_o   = led_q;
    assign phase_o = phase_q;

endmodule

// File: rtl/led_pwm_ctrl.sv
// AXI-Lite LED controller: independent write/read FSMs, register file and the effects generator.
module led_pwm_ctrl
    import led_pkg::*;
#(
    parameter int unsigned NUM_LEDS  = 8,
    parameter int unsigned PWM_BITS  = 8,
    parameter logic [31:0] BASE_ADDR = 32'h0000_0100
) (
    AXI_LITE.slave              axi,
    output logic [NUM_LEDS-1:0] led
);

    wr_state_e wr_state_q, wr_state_d;
    rd_state_e rd_state_q, rd_state_d;

    logic [31:2]         awaddr_q, awaddr_d;
    logic [1:0]          bresp_q, bresp_d;
    logic [31:0]         rdata_q, rdata_d;
    logic [1:0]          rresp_q, rresp_d;
    logic [NUM_LEDS-1:0] led_val_q, led_val_d;
    logic [NUM_LEDS-1:0] led_mode_q, led_mode_d;
    logic [31:0]         blink_half_q, blink_half_d;
    logic [PWM_BITS:0]   pwm_duty_q, pwm_duty_d;

    logic        aw_fire, w_fire, ar_fire;
    logic        wr_hit, wr_map, wr_ok, rd_hit, rd_map;
    logic [7:0]  wr_off, rd_off;
    logic [31:0] wr_cur, wr_new, rd_word;
    logic        blink_restart, blink_phase;
    logic        unused_addr_lsbs;

    assign unused_addr_lsbs = ^{axi.awaddr[1:0], axi.araddr[1:0]};

    // Write FSM
    always_comb begin
        wr_state_d = wr_state_q;
        unique case (wr_state_q)
            StWAddr: if (axi.awvalid) wr_state_d = StWData;
            StWData: if (axi.wvalid)  wr_state_d = StWResp;
            StWResp: if (axi.bready)  wr_state_d = StWAddr;
            default: wr_state_d = StWAddr;
        endcase
    end

    // Read FSM
    always_comb begin
        rd_state_d = rd_state_q;
        unique case (rd_state_q)
            StRAddr: if (axi.arvalid) rd_state_d = StRData;
            StRData: if (axi.rready)  rd_state_d = StRAddr;
            default: rd_state_d = StRAddr;
        endcase
    end

    always_comb begin
        axi.awready = (wr_state_q == StWAddr);
        axi.wready  = (wr_state_q == StWData);
        axi.bvalid  = (wr_state_q == StWResp);
        axi.bresp   = bresp_q;
        axi.arready = (rd_state_q == StRAddr);
        axi.rvalid  = (rd_state_q == StRData);
        axi.rdata   = rdata_q;
        axi.rresp   = rresp_q;
    end

    assign aw_fire = (wr_state_q == StWAddr) && axi.awvalid;
    assign w_fire  = (wr_state_q == StWData) && axi.wvalid;
    assign ar_fire = (rd_state_q == StRAddr) && axi.arvalid;

    // Write decode: current contents of the addressed RW register, merged with the strobed bytes.
    always_comb begin
        wr_hit = (awaddr_q[31:8] == BASE_ADDR[31:8]);
        wr_off = {awaddr_q[7:2], 2'b00};
        wr_cur = '0;
        wr_map = 1'b1;
        case (wr_off)
            OFF_LED_VAL:    wr_cur = 32'(led_val_q);
            OFF_LED_MODE:   wr_cur = 32'(led_mode_q);
            OFF_BLINK_HALF: wr_cur = blink_half_q;
            OFF_PWM_DUTY:   wr_cur = 32'(pwm_duty_q);
            default:        wr_map = 1'b0;
        endcase
        wr_ok  = wr_hit && wr_map;
        wr_new = apply_strb(wr_cur, axi.wdata, axi.wstrb);
    end

    always_comb begin
        rd_hit  = (axi.araddr[31:8] == BASE_ADDR[31:8]);
        rd_off  = {axi.araddr[7:2], 2'b00};
        rd_word = '0;
        rd_map  = 1'b1;
        case (rd_off)
            OFF_LED_VAL:    rd_word = 32'(led_val_q);
            OFF_LED_MODE:   rd_word = 32'(led_mode_q);
            OFF_BLINK_HALF: rd_word = blink_half_q;
            OFF_PWM_DUTY:   rd_word = 32'(pwm_duty_q);
            OFF_STATUS:     rd_word = {19'd0, 4'(PWM_BITS - 4), blink_phase, 8'(NUM_LEDS)};
            default:        rd_map  = 1'b0;
        endcase
    end

    always_comb begin
        awaddr_d      = awaddr_q;
        bresp_d       = bresp_q;
        rdata_d       = rdata_q;
        rresp_d       = rresp_q;
        led_val_d     = led_val_q;
        led_mode_d    = led_mode_q;
        blink_half_d  = blink_half_q;
        pwm_duty_d    = pwm_duty_q;
        blink_restart = 1'b0;
        if (aw_fire) awaddr_d = axi.awaddr[31:2];
        if (w_fire) begin
            bresp_d = wr_ok ? RESP_OKAY : RESP_SLVERR;
            if (wr_ok) begin
                case (wr_off)
                    OFF_LED_VAL:    led_val_d  = wr_new[NUM_LEDS-1:0];
                    OFF_LED_MODE:   led_mode_d = wr_new[NUM_LEDS-1:0];
                    OFF_BLINK_HALF: begin
                        blink_half_d  = wr_new;
                        blink_restart = 1'b1;
                    end
                    OFF_PWM_DUTY:   pwm_duty_d = wr_new[PWM_BITS:0];
                    default:        ;
                endcase
            end
        end
        // Sampled from pre-write register values, so a coincident write is not visible.
        if (ar_fire) begin
            rdata_d = (rd_hit && rd_map) ? rd_word : '0;
            rresp_d = (rd_hit && rd_map) ? RESP_OKAY : RESP_SLVERR;
        end
    end

    always_ff @(posedge axi.aclk) begin
        if (!axi.aresetn) begin
            wr_state_q   <= StWAddr;
            rd_state_q   <= StRAddr;
            awaddr_q     <= '0;
            bresp_q      <= RESP_OKAY;
            rdata_q      <= '0;
            rresp_q      <= RESP_OKAY;
            led_val_q    <= '0;
            led_mode_q   <= '0;
            blink_half_q <= '0;
            pwm_duty_q   <= {1'b1, {PWM_BITS{1'b0}}};
        end else begin
            wr_state_q   <= wr_state_d;
            rd_state_q   <= rd_state_d;
            awaddr_q     <= awaddr_d;
            bresp_q      <= bresp_d;
            rdata_q      <= rdata_d;
            rresp_q      <= rresp_d;
            led_val_q    <= led_val_d;
            led_mode_q   <= led_mode_d;
            blink_half_q <= blink_half_d;
            pwm_duty_q   <= pwm_duty_d;
        end
    end

    led_fx_gen #(
        .NUM_LEDS (NUM_LEDS),
        .PWM_BITS (PWM_BITS)
    ) u_fx_gen (
        .clk_i        (axi.aclk),
        .rst_ni       (axi.aresetn),
        .led_val_i    (led_val_q),
        .led_mode_i   (led_mode_q),
        .blink_half_i (blink_half_q),
        .pwm_duty_i   (pwm_duty_q),
        .restart_i    (blink_restart),
        .led_o        (led),
        .phase_o      (blink_phase)
    );

endmodule
